nibble_seq: RTL and testbench

Multi-nibble operation sequencer that sits directly upstream of the HC4e 4-bit `alu` and drives its `in_A`, `in_B`, `sel_in` and `carry_in` inputs. It accepts a wide operation of `4*NIBBLES` bits, issues it to the ALU one nibble per cycle starting at the least significant nibble, and chains the ALU `carry_out` into the next nibble's `carry_in`. It collects the result nibbles and returns the full-width result with carry and zero flags over a valid/ready handshake.

---
 rtl/hc4e_pkg.sv | 14 +
 rtl/nibble_seq_if.sv | 32 +++
 rtl/nibble_seq.sv | 94 +++++++++
 tb/tb_nibble_seq.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/hc4e_pkg.sv
// Shared HC4e definitions: ALU op codes and nibble sequencer state encodings.
package hc4e_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_PASS = 3'b111;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/nibble_seq_if.sv
// Request, result and ALU-side signals of the nibble sequencer.
interface nibble_seq_if #(
  parameter int unsigned NIBBLES = 2
);
  logic                   start_valid;
  logic                   start_ready;
  logic [2:0]             op_sel;
  logic [4*NIBBLES-1:0]   op_a;
  logic [4*NIBBLES-1:0]   op_b;
  logic                   carry_init;
  logic [3:0]             alu_a;
  logic [3:0]             alu_b;
  logic [2:0]             alu_sel;
  logic                   alu_cin;
  logic [3:0]             alu_out;
  logic                   alu_cout;
  logic                   res_valid;
  logic                   res_ready;
  logic [4*NIBBLES-1:0]   result;
  logic                   res_carry;
  logic                   res_zero;

  modport master (
    input  start_valid, op_sel, op_a, op_b, carry_init, alu_out, alu_cout, res_ready,
    output start_ready, alu_a, alu_b, alu_sel, alu_cin, res_valid, result, res_carry, res_zero
  );

  modport slave (
    output start_valid, op_sel, op_a, op_b, carry_init, alu_out, alu_cout, res_ready,
    input  start_ready, alu_a, alu_b, alu_sel, alu_cin, res_valid, result, res_carry, res_zero
  );
endinterface

// File: rtl/nibble_seq.sv
// Issues a 4*NIBBLES-bit operation to a 4-bit ALU one nibble per cycle, LSB first,
// chaining carry between nibbles and returning the assembled result.
module nibble_seq
  import hc4e_pkg::*;
#(
  parameter int unsigned NIBBLES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  nibble_seq_if.master   bus
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  seq_state_e    state, state_nx;
  logic [IW-1:0] idx;
  logic          carry_q;
  logic [W-1:0]  result_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [2:0]    sel_q;
  logic          cinit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SEQ_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      SEQ_IDLE: if (bus.start_valid) state_nx = SEQ_RUN;
      SEQ_RUN:  if (idx == LAST)     state_nx = SEQ_DONE;
      SEQ_DONE: if (bus.res_ready)   state_nx = SEQ_IDLE;
      default:                       state_nx = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
      cinit_q  <= 1'b0;
    end else begin
      unique case (state)
        SEQ_IDLE: begin
          if (bus.start_valid) begin
            a_q      <= bus.op_a;
            b_q      <= bus.op_b;
            sel_q    <= bus.op_sel;
            cinit_q  <= bus.carry_init;
            result_q <= '0;
            idx      <= '0;
          end
        end
        SEQ_RUN: begin
          result_q[{idx, 2'b00} +: 4] <= bus.alu_out;
          carry_q                     <= bus.alu_cout;
          if (idx != LAST) idx <= idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

  // ALU inputs are only live in RUN so an idle ALU sees constant zeros.
  always_comb begin
    bus.alu_a   = '0;
    bus.alu_b   = '0;
    bus.alu_sel = '0;
    bus.alu_cin = 1'b0;
    if (state == SEQ_RUN) begin
      bus.alu_a   = a_q[{idx, 2'b00} +: 4];
      bus.alu_b   = b_q[{idx, 2'b00} +: 4];
      bus.alu_sel = sel_q;
      bus.alu_cin = (idx == '0) ? cinit_q : carry_q;
    end
  end

  always_comb begin
    bus.start_ready = (state == SEQ_IDLE);
    bus.res_valid   = (state == SEQ_DONE);
    bus.result      = result_q;
    bus.res_carry   = carry_q;
    bus.res_zero    = (result_q == '0);
  end

endmodule

// File: tb/tb_nibble_seq.sv
// Directed bench for nibble_seq (NIBBLES=2) with a behavioural 4-bit ALU in the loop.
module tb_nibble_seq;
  import hc4e_pkg::*;

  logic clk;
  logic rst_n;
  int unsigned total;
  int unsigned passed;

  nibble_seq_if #(.NIBBLES(2)) bus ();

  nibble_seq #(.NIBBLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: add produces carry, other ops clear it.
  always_comb begin
    logic [4:0] s;
    s            = 5'(bus.alu_a) + 5'(bus.alu_b) + 5'(bus.alu_cin);
    bus.alu_out  = 4'h0;
    bus.alu_cout = 1'b0;
    case (bus.alu_sel)
      ALU_ADD:  begin bus.alu_out = s[3:0]; bus.alu_cout = s[4]; end
      ALU_XOR:  bus.alu_out = bus.alu_a ^ bus.alu_b;
      ALU_PASS: bus.alu_out = bus.alu_a;
      default:  bus.alu_out = 4'h0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b,
                          input logic cin);
    bus.op_sel      = sel;
    bus.op_a        = a;
    bus.op_b        = b;
    bus.carry_init  = cin;
    bus.start_valid = 1'b1;
    tick();  // E0
    bus.start_valid = 1'b0;
    bus.op_a        = 8'h00;
    bus.op_b        = 8'h00;
  endtask

  task automatic run_op(input string tag, input logic [2:0] sel, input logic [7:0] a,
                        input logic [7:0] b, input logic cin, input logic [7:0] exp_res,
                        input logic exp_c);
    chk({tag, "_idle_ready"}, 32'(bus.start_ready), 32'd1);
    start_op(sel, a, b, cin);
    chk({tag, "_run_ready"}, 32'(bus.start_ready), 32'd0);
    chk({tag, "_n0_a"}, 32'(bus.alu_a), 32'(a[3:0]));
    chk({tag, "_n0_cin"}, 32'(bus.alu_cin), 32'(cin));
    tick();  // E1
    chk({tag, "_valid_e1"}, 32'(bus.res_valid), 32'd0);
    chk({tag, "_n1_b"}, 32'(bus.alu_b), 32'(b[7:4]));
    tick();  // E2
    chk({tag, "_valid_e2"}, 32'(bus.res_valid), 32'd1);
    chk({tag, "_result"}, 32'(bus.result), 32'(exp_res));
    chk({tag, "_carry"}, 32'(bus.res_carry), 32'(exp_c));
    chk({tag, "_zero"}, 32'(bus.res_zero), 32'(exp_res == 8'h00));
    chk({tag, "_done_alu"}, 32'({bus.alu_a, bus.alu_b, bus.alu_sel, bus.alu_cin}), 32'd0);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk({tag, "_back_idle"}, 32'({bus.start_ready, bus.res_valid}), 32'b10);
  endtask

  initial begin
    total           = 0;
    passed          = 0;
    rst_n           = 1'b0;
    bus.start_valid = 1'b0;
    bus.op_sel      = 3'd0;
    bus.op_a        = 8'h00;
    bus.op_b        = 8'h00;
    bus.carry_init  = 1'b0;
    bus.res_ready   = 1'b0;
    #2;
    chk("rst_ready", 32'(bus.start_ready), 32'd1);
    chk("rst_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_carry", 32'(bus.res_carry), 32'd0);
    chk("rst_zero", 32'(bus.res_zero), 32'd1);
    chk("rst_alu", 32'({bus.alu_a, bus.alu_b, bus.alu_sel, bus.alu_cin}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_op("add", ALU_ADD, 8'h35, 8'h13, 1'b0, 8'h48, 1'b0);

    // Carry chain: check nibble-1 carry-in explicitly.
    start_op(ALU_ADD, 8'h0F, 8'h01, 1'b0);
    tick();
    chk("cprop_cin", 32'(bus.alu_cin), 32'd1);
    chk("cprop_a1", 32'(bus.alu_a), 32'd0);
    tick();
    chk("cprop_result", 32'(bus.result), 32'h10);
    chk("cprop_carry", 32'(bus.res_carry), 32'd0);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;

    run_op("ovf", ALU_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("addcin", ALU_ADD, 8'h35, 8'h13, 1'b1, 8'h49, 1'b0);
    run_op("xor", ALU_XOR, 8'hCA, 8'hA5, 1'b0, 8'h6F, 1'b0);
    run_op("pass", ALU_PASS, 8'hA0, 8'h55, 1'b0, 8'hA0, 1'b0);

    // Backpressure with a competing request pulsed during DONE.
    bus.res_ready = 1'b1;  // no effect outside DONE
    start_op(ALU_ADD, 8'h12, 8'h34, 1'b0);
    bus.res_ready = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.start_valid = i[0];
      bus.op_a        = 8'hEE;
      bus.op_b        = 8'h11;
      tick();
      chk("bp_valid", 32'(bus.res_valid), 32'd1);
      chk("bp_ready", 32'(bus.start_ready), 32'd0);
      chk("bp_result", 32'(bus.result), 32'h46);
    end
    bus.start_valid = 1'b0;
    bus.res_ready   = 1'b1;
    tick();
    bus.res_ready   = 1'b0;
    chk("bp_exit", 32'({bus.start_ready, bus.res_valid}), 32'b10);
    tick();
    chk("bp_no_second", 32'({bus.start_ready, bus.res_valid}), 32'b10);

    // Reset during RUN, while nibble 1 has a live carry-in.
    start_op(ALU_ADD, 8'hFF, 8'h01, 1'b0);
    tick();
    chk("mid_cin", 32'(bus.alu_cin), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_valid", 32'(bus.res_valid), 32'd0);
    chk("mid_alu", 32'({bus.alu_a, bus.alu_b, bus.alu_sel, bus.alu_cin}), 32'd0);
    chk("mid_ready", 32'(bus.start_ready), 32'd1);
    chk("mid_zero", 32'(bus.res_zero), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_no_valid", 32'(bus.res_valid), 32'd0);
    end
    run_op("post_rst", ALU_ADD, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
